lcd_800_480_timing_gen: RTL



---
 rtl/lcd_timing_pkg.sv | 26 ++
 rtl/lcd_sync_counter.sv | 42 ++++
 rtl/lcd_800_480_timing_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Geometry, counter widths and controller states shared by the 800x480 RGB panel timing generator.
package lcd_timing_pkg;

    localparam int LCD_H_ACTIVE = 800;
    localparam int LCD_H_FP     = 210;
    localparam int LCD_H_SYNC   = 1;
    localparam int LCD_H_BP     = 46;
    localparam int LCD_V_ACTIVE = 480;
    localparam int LCD_V_FP     = 22;
    localparam int LCD_V_SYNC   = 1;
    localparam int LCD_V_BP     = 23;

    localparam int LCD_H_TOTAL = LCD_H_ACTIVE + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;
    localparam int LCD_V_TOTAL = LCD_V_ACTIVE + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lcd_state_t;

endpackage

// File: rtl/lcd_sync_counter.sv
// One timing axis: position counter ordered active, front porch, sync, back porch,
// with region decode and a wrap flag raised on the last position.
module lcd_sync_counter
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = LCD_H_ACTIVE,
    parameter int FP     = LCD_H_FP,
    parameter int SYNC   = LCD_H_SYNC,
    parameter int BP     = LCD_H_BP,
    parameter int W      = H_CNT_W
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

    assign wrap   = (cnt == LAST);
    assign active = (cnt < ACT_END);
    assign sync   = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

endmodule

// File: rtl/lcd_800_480_timing_gen.sv
// RGB-LCD timing generator: issues (x,y) pixel requests and drives DE/HS/VS/RGB
// two clocks later so the returned pixel lands on the pins aligned with DE.
module lcd_800_480_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RGB_W    = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pix_req,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             frame_start,
    output logic             lcd_de,
    output logic             lcd_hs,
    output logic             lcd_vs,
    output logic [RGB_W-1:0] lcd_rgb
);

    lcd_state_t           state;
    logic                 run_now;
    logic [H_CNT_W-1:0]   h_cnt;
    logic [V_CNT_W-1:0]   v_cnt;
    logic                 h_active, h_sync, h_wrap;
    logic                 v_active, v_sync, v_wrap;
    logic                 hs_s0, vs_s0;
    logic                 de_s1, hs_s1, vs_s1;

    // IDLE holds the counters at 0, so a raised en starts scanning on the very next edge.
    assign run_now = (state == RUN) || en;

    lcd_sync_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (H_CNT_W)
    ) u_h_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!run_now),
        .inc    (run_now),
        .cnt    (h_cnt),
        .active (h_active),
        .sync   (h_sync),
        .wrap   (h_wrap)
    );

    lcd_sync_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (V_CNT_W)
    ) u_v_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!run_now),
        .inc    (run_now && h_wrap),
        .cnt    (v_cnt),
        .active (v_active),
        .sync   (v_sync),
        .wrap   (v_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pix_req     <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            hs_s0       <= 1'b0;
            vs_s0       <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (h_wrap && v_wrap && !en) state <= IDLE;
                default: state <= IDLE;
            endcase
            pix_req     <= run_now && h_active && v_active;
            frame_start <= run_now && (h_cnt == '0) && (v_cnt == '0);
            hs_s0       <= run_now && h_sync;
            vs_s0       <= run_now && v_sync;
            if (run_now && h_active && v_active) begin
                x <= X_W'(h_cnt);
                y <= Y_W'(v_cnt);
            end
        end
    end

    // Stage 1 waits for the graphics source; stage 2 captures its pixel together with the syncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_s1   <= 1'b0;
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            lcd_de  <= 1'b0;
            lcd_hs  <= ~HS_POL;
            lcd_vs  <= ~VS_POL;
            lcd_rgb <= '0;
        end else begin
            de_s1   <= pix_req;
            hs_s1   <= hs_s0;
            vs_s1   <= vs_s0;
            lcd_de  <= de_s1;
            lcd_hs  <= hs_s1 ? HS_POL : ~HS_POL;
            lcd_vs  <= vs_s1 ? VS_POL : ~VS_POL;
            lcd_rgb <= de_s1 ? rgb_in : '0;
        end
    end

endmodule
